// File: rtl/pmu_pkg.sv
// Shared definitions for the pmu configuration-load blocks: the load
// sequencer state encoding and the default chain/word geometry.
package pmu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESET,
    SHIFT,
    VERIFY,
    RELEASE,
    DONE,
    ERROR
  } load_state_t;

  localparam int CCFF_CHAIN_LEN = 2015;
  localparam int CCFF_WORD_W    = 32;

endpackage

// File: rtl/ccff_serializer.sv
// Word buffer and prog_clk generator for the ccff chain. Each buffered word is
// shifted out LSB-first on data. Every bit has a low setup phase of PROG_DIV
// cycles followed by a high phase of PROG_DIV cycles. The next bit appears when
// progclk falls. Everything clears whenever enable drops.
module ccff_serializer import pmu_pkg::*; #(
  parameter int WORD_W   = CCFF_WORD_W,
  parameter int PROG_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [WORD_W-1:0] word,
  input  logic              word_valid,
  output logic              progclk,
  output logic              data,
  output logic              bit_strobe,
  output logic              bit_done,
  output logic              buf_empty
);

  localparam int DIV_W = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam int BL_W  = $clog2(WORD_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PROG_DIV - 1);
  localparam logic [BL_W-1:0]  BL_FULL  = BL_W'(WORD_W);

  logic [WORD_W-1:0] sh;
  logic [BL_W-1:0]   bits_left;
  logic [DIV_W-1:0]  div_cnt;
  logic              phase_end;

  assign buf_empty  = (bits_left == '0);
  assign phase_end  = (div_cnt == DIV_LAST);
  assign bit_strobe = enable && !buf_empty && !progclk && phase_end;
  assign bit_done   = enable && progclk && phase_end;
  assign data       = sh[0];

  // Load a word when the buffer is empty, then alternate low/high phases per bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh        <= '0;
      bits_left <= '0;
      div_cnt   <= '0;
      progclk   <= 1'b0;
    end else if (!enable) begin
      sh        <= '0;
      bits_left <= '0;
      div_cnt   <= '0;
      progclk   <= 1'b0;
    end else if (buf_empty) begin
      progclk <= 1'b0;
      div_cnt <= '0;
      if (word_valid) begin
        sh        <= word;
        bits_left <= BL_FULL;
      end
    end else if (phase_end) begin
      div_cnt <= '0;
      if (!progclk) begin
        progclk <= 1'b1;
      end else begin
        progclk   <= 1'b0;
        sh        <= sh >> 1;
        bits_left <= bits_left - BL_W'(1);
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ccff_load_ctrl.sv
// Configuration-chain load sequencer. It resets the chain, streams bitstream words
// through the serializer, and checks that the first bit reappears at the chain tail.
// After a good check it releases the fabric.
module ccff_load_ctrl import pmu_pkg::*; #(
  parameter int CHAIN_LEN  = CCFF_CHAIN_LEN,
  parameter int WORD_W     = CCFF_WORD_W,
  parameter int PROG_DIV   = 2,
  parameter int PRESET_CYC = 4
) (
  input  logic                             tck_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic [WORD_W-1:0]                word_i,
  input  logic                             word_valid_i,
  output logic                             word_ready_o,
  output logic                             config_enable_o,
  output logic                             pReset_o,
  output logic                             progclk_o,
  output logic                             data_o,
  input  logic                             ccff_tail_i,
  output logic                             fpga_rst_o,
  output logic                             fpga_clk_en_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             tail_err_o,
  output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_cnt_o
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(CHAIN_LEN);
  localparam logic [15:0]      PRESET_LAST = 16'(PRESET_CYC - 1);
  localparam logic [15:0]      VERIFY_LAST = 16'(PROG_DIV - 1);

  load_state_t state, state_next;
  logic [15:0] cyc_cnt;
  logic        marker;
  logic        tail_err;
  logic        ser_en;
  logic        bit_strobe;
  logic        bit_done;
  logic        buf_empty;
  logic        start_ok;
  logic        verify_end;

  assign start_ok   = start_i && !abort_i &&
                      (state == IDLE || state == DONE || state == ERROR);
  assign verify_end = (state == VERIFY) && (cyc_cnt == VERIFY_LAST);
  assign ser_en       = (state == SHIFT) && !abort_i;
  assign word_ready_o = ser_en && buf_empty;
  assign tail_err_o   = tail_err;

  ccff_serializer #(
    .WORD_W   (WORD_W),
    .PROG_DIV (PROG_DIV)
  ) u_ser (
    .clk        (tck_i),
    .rst        (rst_i),
    .enable     (ser_en),
    .word       (word_i),
    .word_valid (word_valid_i),
    .progclk    (progclk_o),
    .data       (data_o),
    .bit_strobe (bit_strobe),
    .bit_done   (bit_done),
    .buf_empty  (buf_empty)
  );

  // State register.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and Moore outputs. Abort overrides every other transition.
  always_comb begin
    state_next      = state;
    config_enable_o = 1'b0;
    pReset_o        = 1'b0;
    fpga_rst_o      = 1'b1;
    fpga_clk_en_o   = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_next = PRESET;
      end
      PRESET: begin
        config_enable_o = 1'b1;
        pReset_o        = 1'b1;
        busy_o          = 1'b1;
        if (cyc_cnt == PRESET_LAST) state_next = SHIFT;
      end
      SHIFT: begin
        config_enable_o = 1'b1;
        busy_o          = 1'b1;
        if (bit_done && bit_cnt_o == CNT_MAX) state_next = VERIFY;
      end
      VERIFY: begin
        config_enable_o = 1'b1;
        busy_o          = 1'b1;
        if (verify_end) state_next = (ccff_tail_i == marker) ? RELEASE : ERROR;
      end
      RELEASE: begin
        busy_o        = 1'b1;
        fpga_rst_o    = (cyc_cnt == 16'd0);
        fpga_clk_en_o = (cyc_cnt == 16'd2);
        if (cyc_cnt == 16'd2) state_next = DONE;
      end
      DONE: begin
        done_o        = 1'b1;
        fpga_clk_en_o = 1'b1;
        fpga_rst_o    = 1'b0;
        if (start_i) state_next = PRESET;
      end
      ERROR: begin
        if (start_i) state_next = PRESET;
      end
      default: state_next = IDLE;
    endcase
    if (abort_i) state_next = IDLE;
  end

  // Shared phase timer for PRESET, VERIFY and RELEASE. It restarts on every state change.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i)                                          cyc_cnt <= '0;
    else if (state_next != state)                       cyc_cnt <= '0;
    else if (state inside {PRESET, VERIFY, RELEASE})    cyc_cnt <= cyc_cnt + 16'd1;
    else                                                cyc_cnt <= '0;
  end

  // Bit counter advances with each progclk rise and saturates at the chain length.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i)                                 bit_cnt_o <= '0;
    else if (start_ok || abort_i)              bit_cnt_o <= '0;
    else if (bit_strobe && bit_cnt_o != CNT_MAX) bit_cnt_o <= bit_cnt_o + CNT_W'(1);
  end

  // The first bit clocked into the chain is the marker expected back at the tail.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i)                              marker <= 1'b0;
    else if (start_ok)                      marker <= 1'b0;
    else if (bit_strobe && bit_cnt_o == '0) marker <= data_o;
  end

  // Tail error is sticky until the next start or reset. Abort does not clear it.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i)                                                tail_err <= 1'b0;
    else if (start_ok)                                        tail_err <= 1'b0;
    else if (verify_end && !abort_i && ccff_tail_i != marker) tail_err <= 1'b1;
  end

endmodule

// File: tb/tb_ccff_load_ctrl.sv
// Scoreboard bench for ccff_load_ctrl. The stimulus queues the expected chain bits.
// A monitor pops one bit on every progclk rise and checks it.
// Directed checks cover reset, the load phases, abort, stall and async reset.
module tb_ccff_load_ctrl;

  localparam int CHAIN      = 40;
  localparam int WORD_W     = 32;
  localparam int PROG_DIV   = 2;
  localparam int PRESET_CYC = 4;
  localparam int CNT_W      = $clog2(CHAIN + 1);

  logic              tck = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              abort_i;
  logic [WORD_W-1:0] word_i;
  logic              word_valid_i;
  logic              word_ready_o;
  logic              config_enable_o;
  logic              pReset_o;
  logic              progclk_o;
  logic              data_o;
  logic              ccff_tail_i;
  logic              fpga_rst_o;
  logic              fpga_clk_en_o;
  logic              busy_o;
  logic              done_o;
  logic              tail_err_o;
  logic [CNT_W-1:0]  bit_cnt_o;

  int   errors   = 0;
  int   checks   = 0;
  int   pc_rises = 0;
  logic sb[$];
  logic pc_prev  = 1'b0;
  logic mon_bit;
  logic tail_invert = 1'b0;
  logic [CHAIN-1:0] chain = '0;

  ccff_load_ctrl #(
    .CHAIN_LEN  (CHAIN),
    .WORD_W     (WORD_W),
    .PROG_DIV   (PROG_DIV),
    .PRESET_CYC (PRESET_CYC)
  ) dut (
    .tck_i           (tck),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .word_i          (word_i),
    .word_valid_i    (word_valid_i),
    .word_ready_o    (word_ready_o),
    .config_enable_o (config_enable_o),
    .pReset_o        (pReset_o),
    .progclk_o       (progclk_o),
    .data_o          (data_o),
    .ccff_tail_i     (ccff_tail_i),
    .fpga_rst_o      (fpga_rst_o),
    .fpga_clk_en_o   (fpga_clk_en_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .tail_err_o      (tail_err_o),
    .bit_cnt_o       (bit_cnt_o)
  );

  always #5 tck = ~tck;

  // Chain model: a CHAIN-deep shift register, cleared by pReset and clocked by progclk.
  always @(posedge progclk_o or posedge pReset_o) begin
    if (pReset_o) chain <= '0;
    else          chain <= {chain[CHAIN-2:0], data_o};
  end

  assign ccff_tail_i = chain[CHAIN-1] ^ tail_invert;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: on every progclk rise, pop the next expected bit and compare it with data_o.
  always @(negedge tck) begin
    if (progclk_o && !pc_prev) begin
      pc_rises++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL progclk_edge: got unexpected rising edge expected none");
      end else begin
        mon_bit = sb.pop_front();
        checkOutput("data_o_bit", {31'b0, data_o}, {31'b0, mon_bit});
      end
    end
    pc_prev = progclk_o;
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cfg_en"},   {31'b0, config_enable_o}, 0);
    checkOutput({tag, "_preset"},   {31'b0, pReset_o}, 0);
    checkOutput({tag, "_progclk"},  {31'b0, progclk_o}, 0);
    checkOutput({tag, "_data"},     {31'b0, data_o}, 0);
    checkOutput({tag, "_fpga_rst"}, {31'b0, fpga_rst_o}, 1);
    checkOutput({tag, "_clk_en"},   {31'b0, fpga_clk_en_o}, 0);
    checkOutput({tag, "_ready"},    {31'b0, word_ready_o}, 0);
    checkOutput({tag, "_busy"},     {31'b0, busy_o}, 0);
    checkOutput({tag, "_done"},     {31'b0, done_o}, 0);
    checkOutput({tag, "_tail_err"}, {31'b0, tail_err_o}, 0);
    checkOutput({tag, "_bit_cnt"},  32'(bit_cnt_o), 0);
  endtask

  task automatic pulseStart();
    @(negedge tck) start_i = 1'b1;
    @(negedge tck) start_i = 1'b0;
  endtask

  // Queue the bits the chain should see from this word, then hand it over.
  task automatic applyStimulus(input logic [31:0] w, input int nbits);
    int n;
    for (int i = 0; i < nbits; i++) sb.push_back(w[i]);
    @(negedge tck);
    word_i       = w;
    word_valid_i = 1'b1;
    n = 0;
    while (!word_ready_o && n < 1000) begin
      @(negedge tck);
      n++;
    end
    if (!word_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL word_accept: got no ready expected ready within 1000 cycles");
    end else begin
      @(posedge tck);
    end
    @(negedge tck);
    word_valid_i = 1'b0;
    word_i       = '0;
  endtask

  task automatic waitEnd(input int max_cyc, output int rst_fall, output int en_rise);
    int n;
    n = 0;
    rst_fall = -1;
    en_rise  = -1;
    while (!(done_o || tail_err_o) && n < max_cyc) begin
      @(negedge tck);
      n++;
      if (!fpga_rst_o && rst_fall < 0) rst_fall = n;
      if (fpga_clk_en_o && en_rise < 0) en_rise = n;
    end
    checks++;
    if (!(done_o || tail_err_o)) begin
      errors++;
      $display("[TB] FAIL load_end: got no done/error expected one within %0d cycles", max_cyc);
    end
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, rf, er;
    logic pc_bad, cnt_bad, cfg_bad, pre_bad, busy_bad;

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; word_valid_i = 1'b0; word_i = '0;
    repeat (3) @(negedge tck);
    checkResetValues("reset");
    rst_i = 1'b0;
    @(negedge tck);
    checkResetValues("idle");

    // Nominal load with PRESET timing measured on the way in.
    $display("[TB] nominal load");
    pc_rises = 0;
    pulseStart();
    checkOutput("preset_cfg_en", {31'b0, config_enable_o}, 1);
    checkOutput("preset_busy", {31'b0, busy_o}, 1);
    n = 0; pc_bad = 1'b0; cfg_bad = 1'b0;
    while (pReset_o && n < 20) begin
      n++;
      if (progclk_o) pc_bad = 1'b1;
      if (!config_enable_o) cfg_bad = 1'b1;
      @(negedge tck);
    end
    checkOutput("preset_len", n, PRESET_CYC);
    checkOutput("preset_no_progclk", {31'b0, pc_bad}, 0);
    checkOutput("preset_cfg_hold", {31'b0, cfg_bad}, 0);
    applyStimulus(32'hA5A5A5A5, 32);
    applyStimulus(32'h000000C3, 8);
    waitEnd(2000, rf, er);
    checkOutput("nom_done", {31'b0, done_o}, 1);
    checkOutput("nom_tail_err", {31'b0, tail_err_o}, 0);
    checkOutput("nom_clk_en", {31'b0, fpga_clk_en_o}, 1);
    checkOutput("nom_fpga_rst", {31'b0, fpga_rst_o}, 0);
    checkOutput("nom_cfg_en", {31'b0, config_enable_o}, 0);
    checkOutput("nom_bit_cnt", 32'(bit_cnt_o), CHAIN);
    checkOutput("nom_edges", pc_rises, CHAIN);
    checkOutput("nom_sb_empty", sb.size(), 0);
    checkOutput("nom_release_order", er - rf, 1);

    // Restart from DONE, then stall between words; a start during the stall is ignored.
    $display("[TB] stall");
    pc_rises = 0;
    pulseStart();
    checkOutput("restart_clk_en", {31'b0, fpga_clk_en_o}, 0);
    checkOutput("restart_fpga_rst", {31'b0, fpga_rst_o}, 1);
    checkOutput("restart_done", {31'b0, done_o}, 0);
    checkOutput("restart_preset", {31'b0, pReset_o}, 1);
    applyStimulus(32'h12345678, 32);
    n = 0;
    while (!(bit_cnt_o == CNT_W'(32) && word_ready_o) && n < 1000) begin
      @(negedge tck);
      n++;
    end
    checkOutput("stall_reach_32", 32'(bit_cnt_o), 32);
    pc_bad = 1'b0; cnt_bad = 1'b0; pre_bad = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start_i = (i == 10);
      @(negedge tck);
      if (progclk_o) pc_bad = 1'b1;
      if (bit_cnt_o != CNT_W'(32)) cnt_bad = 1'b1;
      if (pReset_o) pre_bad = 1'b1;
      if (!busy_o) busy_bad = 1'b1;
    end
    start_i = 1'b0;
    checkOutput("stall_progclk_low", {31'b0, pc_bad}, 0);
    checkOutput("stall_cnt_frozen", {31'b0, cnt_bad}, 0);
    checkOutput("busy_start_no_preset", {31'b0, pre_bad}, 0);
    checkOutput("stall_busy", {31'b0, busy_bad}, 0);
    applyStimulus(32'hFFFFFF0F, 8);
    waitEnd(2000, rf, er);
    checkOutput("stall_done", {31'b0, done_o}, 1);
    checkOutput("stall_tail_err", {31'b0, tail_err_o}, 0);
    checkOutput("stall_bit_cnt", 32'(bit_cnt_o), CHAIN);
    checkOutput("stall_edges", pc_rises, CHAIN);
    checkOutput("stall_sb_empty", sb.size(), 0);

    // Tail mismatch leads to ERROR; the next start clears the sticky flag.
    $display("[TB] tail mismatch");
    tail_invert = 1'b1;
    pulseStart();
    applyStimulus(32'hDEADBEEF, 32);
    applyStimulus(32'h0000005A, 8);
    waitEnd(2000, rf, er);
    checkOutput("err_tail_err", {31'b0, tail_err_o}, 1);
    checkOutput("err_done", {31'b0, done_o}, 0);
    checkOutput("err_clk_en", {31'b0, fpga_clk_en_o}, 0);
    checkOutput("err_fpga_rst", {31'b0, fpga_rst_o}, 1);
    checkOutput("err_cfg_en", {31'b0, config_enable_o}, 0);
    checkOutput("err_busy", {31'b0, busy_o}, 0);
    checkOutput("err_sb_empty", sb.size(), 0);
    repeat (3) @(negedge tck);
    checkOutput("err_sticky", {31'b0, tail_err_o}, 1);
    tail_invert = 1'b0;
    pulseStart();
    checkOutput("err_restart_clear", {31'b0, tail_err_o}, 0);
    checkOutput("err_restart_preset", {31'b0, pReset_o}, 1);
    checkOutput("err_restart_bit_cnt", 32'(bit_cnt_o), 0);
    @(negedge tck) abort_i = 1'b1;
    @(negedge tck) abort_i = 1'b0;
    checkResetValues("abort_preset");

    // Abort while progclk is high at bit 17; the restart reloads from bit 0.
    $display("[TB] abort mid-shift");
    pc_rises = 0;
    pulseStart();
    applyStimulus(32'hA5A5A5A5, 32);
    n = 0;
    while (!(bit_cnt_o == CNT_W'(17) && progclk_o) && n < 1000) begin
      @(negedge tck);
      n++;
    end
    checkOutput("abort_at_17", 32'(bit_cnt_o), 17);
    abort_i = 1'b1;
    @(negedge tck);
    abort_i = 1'b0;
    checkOutput("abort_progclk", {31'b0, progclk_o}, 0);
    checkOutput("abort_cfg_en", {31'b0, config_enable_o}, 0);
    checkOutput("abort_busy", {31'b0, busy_o}, 0);
    checkOutput("abort_bit_cnt", 32'(bit_cnt_o), 0);
    checkOutput("abort_ready", {31'b0, word_ready_o}, 0);
    sb.delete();
    pc_rises = 0;
    pulseStart();
    applyStimulus(32'h0F0F0F0F, 32);
    applyStimulus(32'h00000099, 8);
    waitEnd(2000, rf, er);
    checkOutput("reload_done", {31'b0, done_o}, 1);
    checkOutput("reload_tail_err", {31'b0, tail_err_o}, 0);
    checkOutput("reload_bit_cnt", 32'(bit_cnt_o), CHAIN);
    checkOutput("reload_edges", pc_rises, CHAIN);
    checkOutput("reload_sb_empty", sb.size(), 0);

    // Asynchronous reset between clock edges in the middle of SHIFT.
    $display("[TB] async reset");
    pulseStart();
    applyStimulus(32'h3C3C3C3C, 32);
    n = 0;
    while (bit_cnt_o < CNT_W'(5) && n < 1000) begin
      @(negedge tck);
      n++;
    end
    checkOutput("async_pre_busy", {31'b0, busy_o}, 1);
    #2 rst_i = 1'b1;
    #1 checkResetValues("async_rst");
    @(negedge tck) rst_i = 1'b0;
    sb.delete();
    @(negedge tck);
    checkOutput("post_rst_busy", {31'b0, busy_o}, 0);
    checkOutput("post_rst_progclk", {31'b0, progclk_o}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
